// File: rtl/thr_table_loader_pkg.sv
// Shared types and helpers for the threshold-table loader.
package thr_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STREAM = 3'd1,
        ST_RAMP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } thr_ld_state_t;

    localparam logic MODE_STREAM = 1'b0;
    localparam logic MODE_RAMP   = 1'b1;

    // Clamp a value to the largest legal threshold (the vector width).
    function automatic logic [31:0] thr_sat(input logic [31:0] value, input logic [31:0] limit);
        logic [31:0] res;
        if (value > limit) begin
            res = limit;
        end else begin
            res = value;
        end
        return res;
    endfunction

endpackage

// File: rtl/thr_table_loader_ramp_gen.sv
// Linear ramp source: base on load, +step per enabled cycle, output clamped
// to VECTOR_WIDTH. The accumulator is wide enough never to wrap over one table.
module thr_ramp_gen
    import thr_loader_pkg::*;
#(
    parameter int VECTOR_WIDTH = 920,
    parameter int CNT_WIDTH    = $clog2(VECTOR_WIDTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic                 en_i,
    input  logic [CNT_WIDTH-1:0] base_i,
    input  logic [CNT_WIDTH-1:0] step_i,
    output logic [CNT_WIDTH-1:0] value_o
);

    localparam int ACC_W = 2 * CNT_WIDTH + 1;

    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [CNT_WIDTH-1:0] step_q, step_d;
    logic [31:0]          sat_s;
    logic                 unused_sat_s;

    // Next accumulator value: reload on start, advance while enabled.
    always_comb begin
        acc_d  = acc_q;
        step_d = step_q;
        if (load_i) begin
            acc_d  = ACC_W'(base_i);
            step_d = step_i;
        end else if (en_i) begin
            acc_d = acc_q + ACC_W'(step_q);
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator and latched step registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q  <= '0;
            step_q <= '0;
        end else begin
            acc_q  <= acc_d;
            step_q <= step_d;
        end
    end

    assign sat_s        = thr_sat(32'(acc_q), 32'(VECTOR_WIDTH));
    assign value_o      = sat_s[CNT_WIDTH-1:0];
    assign unused_sat_s = ^sat_s[31:CNT_WIDTH];

endmodule

// File: rtl/thr_table_loader.sv
// Loads the per-popcount threshold BRAMs from a config stream or a linear ramp.
// Optional stream monotonicity check enabled by defining THR_MONO_CHECK_EN.
module thr_table_loader
    import thr_loader_pkg::*;
#(
    parameter int VECTOR_WIDTH = 920,
    parameter int CNT_WIDTH    = $clog2(VECTOR_WIDTH + 1),
    parameter int NUM_BANKS    = 1,
    parameter int S_DATA_WIDTH = 32
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    start,
    input  logic                    mode,
    input  logic [NUM_BANKS-1:0]    bank_mask,
    input  logic [CNT_WIDTH-1:0]    ramp_base,
    input  logic [CNT_WIDTH-1:0]    ramp_step,
    input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [CNT_WIDTH-1:0]    bram_addr,
    output logic [CNT_WIDTH-1:0]    bram_wrdata,
    output logic                    bram_en,
    output logic [NUM_BANKS-1:0]    bram_we,
    output logic                    busy,
    output logic                    done,
    output logic                    err_len,
    output logic                    err_mono
);

    localparam logic [CNT_WIDTH-1:0] ADDR_LAST = CNT_WIDTH'(VECTOR_WIDTH);

    thr_ld_state_t        state_q, state_d;
    logic [NUM_BANKS-1:0] mask_q, mask_d;
    logic [CNT_WIDTH-1:0] addr_q, addr_d;
    logic [NUM_BANKS-1:0] we_q, we_d;
    logic                 en_q;
    logic [CNT_WIDTH-1:0] waddr_q, waddr_d;
    logic [CNT_WIDTH-1:0] wdata_q, wdata_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_len_q, err_len_d;
    logic                 tready_q;

    logic                 start_ok_s;
    logic                 ramp_load_s;
    logic                 ramp_en_s;
    logic [CNT_WIDTH-1:0] ramp_val_s;
    logic [31:0]          stream_sat_s;
    logic [CNT_WIDTH-1:0] stream_val_s;
    logic                 unused_s;

    assign start_ok_s   = (state_q == ST_IDLE) && start && (|bank_mask);
    assign stream_sat_s = thr_sat(32'(s_axis_tdata[CNT_WIDTH-1:0]), 32'(VECTOR_WIDTH));
    assign stream_val_s = stream_sat_s[CNT_WIDTH-1:0];
    assign unused_s     = ^{s_axis_tdata[S_DATA_WIDTH-1:CNT_WIDTH], stream_sat_s[31:CNT_WIDTH]};

    thr_ramp_gen #(
        .VECTOR_WIDTH (VECTOR_WIDTH),
        .CNT_WIDTH    (CNT_WIDTH)
    ) u_ramp (
        .clk_i   (aclk),
        .rst_ni  (aresetn),
        .load_i  (ramp_load_s),
        .en_i    (ramp_en_s),
        .base_i  (ramp_base),
        .step_i  (ramp_step),
        .value_o (ramp_val_s)
    );

    // Load sequencer: next state, write request and status flags.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        addr_d      = addr_q;
        we_d        = '0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_len_d   = err_len_q;
        ramp_load_s = 1'b0;
        ramp_en_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) begin
                    mask_d      = bank_mask;
                    addr_d      = '0;
                    busy_d      = 1'b1;
                    err_len_d   = 1'b0;
                    ramp_load_s = 1'b1;
                    state_d     = (mode == MODE_RAMP) ? ST_RAMP : ST_STREAM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RAMP: begin
                ramp_en_s = 1'b1;
                we_d      = mask_q;
                waddr_d   = addr_q;
                wdata_d   = ramp_val_s;
                if (addr_q == ADDR_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    addr_d = addr_q + CNT_WIDTH'(1'b1);
                end
            end
            ST_STREAM: begin
                if (s_axis_tvalid) begin
                    we_d    = mask_q;
                    waddr_d = addr_q;
                    wdata_d = stream_val_s;
                    if (s_axis_tlast) begin
                        // tlast before the final address means the table came up short
                        if (addr_q != ADDR_LAST) begin
                            err_len_d = 1'b1;
                        end else begin
                            err_len_d = err_len_q;
                        end
                        state_d = ST_DONE;
                    end else if (addr_q == ADDR_LAST) begin
                        err_len_d = 1'b1;
                        state_d   = ST_DRAIN;
                    end else begin
                        addr_d = addr_q + CNT_WIDTH'(1'b1);
                    end
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and registered BRAM/status outputs.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            mask_q    <= '0;
            addr_q    <= '0;
            we_q      <= '0;
            en_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_len_q <= 1'b0;
            tready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            en_q      <= |we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_len_q <= err_len_d;
            tready_q  <= (state_d == ST_STREAM) || (state_d == ST_DRAIN);
        end
    end

`ifdef THR_MONO_CHECK_EN
    logic [CNT_WIDTH-1:0] prev_q, prev_d;
    logic                 err_mono_q, err_mono_d;

    // Flag any stream entry smaller than the one written before it.
    always_comb begin
        prev_d     = prev_q;
        err_mono_d = err_mono_q;
        if (start_ok_s) begin
            err_mono_d = 1'b0;
        end else if ((state_q == ST_STREAM) && s_axis_tvalid) begin
            prev_d = stream_val_s;
            if ((addr_q != '0) && (stream_val_s < prev_q)) begin
                err_mono_d = 1'b1;
            end else begin
                err_mono_d = err_mono_q;
            end
        end else begin
            prev_d = prev_q;
        end
    end

    // Previous-value and sticky monotonicity flag registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            prev_q     <= '0;
            err_mono_q <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            err_mono_q <= err_mono_d;
        end
    end

    assign err_mono = err_mono_q;
`else
    assign err_mono = 1'b0;
`endif

    assign s_axis_tready = tready_q;
    assign bram_addr     = waddr_q;
    assign bram_wrdata   = wdata_q;
    assign bram_en       = en_q;
    assign bram_we       = we_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err_len       = err_len_q;

endmodule
